// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM port arbiter.
// Imported by ram_arb_pick and ram_port_arbiter.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_e;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_EXT = 1'b1
    } grant_e;

    // RAM strobes are active-low, so the idle level is 1
    localparam logic STB_OFF = 1'b1;

    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
    endfunction

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational two-way winner selection between the CPU and loader ports.
// Round-robin by default; define RAM_ARB_FIXED_PRIO_EN for fixed CPU priority.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic   cpu_req_i,
    input  logic   ext_req_i,
    input  grant_e last_grant_i,
    output grant_e winner_o
);

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_grant_i;

    // CPU wins whenever it asks; the loader only gets the RAM when the CPU is quiet
    always_comb begin
        winner_o = GNT_CPU;
        if (!cpu_req_i && ext_req_i) begin
            winner_o = GNT_EXT;
        end
    end
`else
    always_comb begin
        winner_o = GNT_CPU;
        if (cpu_req_i && ext_req_i) begin
            // Tie goes to whoever was not served last
            winner_o = (last_grant_i == GNT_EXT) ? GNT_CPU : GNT_EXT;
        end else if (ext_req_i) begin
            winner_o = GNT_EXT;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates the single-port program/data RAM between the CPU and the loader port,
// with a fixed wait-state window per access. RAM_ARB_FIXED_PRIO_EN selects fixed priority.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              Reset_in,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              ext_req,
    input  logic              ext_we,
    input  logic [ADDR_W-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_wdata,
    output logic [DATA_W-1:0] ext_rdata,
    output logic              ext_ack,

    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              ram_rd_n,
    output logic              ram_wr_n,

    output logic              busy,
    output logic              gnt_ext
);

    localparam int CNT_W = cnt_width(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                we_q, we_d;
    grant_e              last_q, last_d;
    logic                gnt_ext_q, gnt_ext_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_n_q, rd_n_d;
    logic                wr_n_q, wr_n_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0]   ext_rdata_q, ext_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                ext_ack_q, ext_ack_d;

    grant_e              winner;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    ram_arb_pick u_pick (
        .cpu_req_i    (cpu_req),
        .ext_req_i    (ext_req),
        .last_grant_i (last_q),
        .winner_o     (winner)
    );

    always_comb begin
        sel_we    = cpu_we;
        sel_addr  = cpu_addr;
        sel_wdata = cpu_wdata;
        if (winner == GNT_EXT) begin
            sel_we    = ext_we;
            sel_addr  = ext_addr;
            sel_wdata = ext_wdata;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        last_d      = last_q;
        gnt_ext_d   = gnt_ext_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_n_d      = rd_n_q;
        wr_n_d      = wr_n_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        cpu_ack_d   = 1'b0;
        ext_ack_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    state_d   = ACCESS;
                    cnt_d     = CNT_INIT;
                    last_d    = winner;
                    gnt_ext_d = (winner == GNT_EXT);
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdata_d   = sel_wdata;
                    rd_n_d    = sel_we ? STB_OFF : ~STB_OFF;
                    wr_n_d    = sel_we ? ~STB_OFF : STB_OFF;
                end
            end

            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = DONE;
                    rd_n_d  = STB_OFF;
                    wr_n_d  = STB_OFF;
                    if (last_q == GNT_EXT) begin
                        ext_ack_d = 1'b1;
                        if (!we_q) ext_rdata_d = ram_rdata;
                    end else begin
                        cpu_ack_d = 1'b1;
                        if (!we_q) cpu_rdata_d = ram_rdata;
                    end
                end
            end

            // DONE never grants, leaving one strobe-free IDLE cycle between accesses
            DONE: state_d = IDLE;

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge Reset_in) begin
        if (Reset_in) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            last_q      <= GNT_EXT;
            gnt_ext_q   <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_n_q      <= STB_OFF;
            wr_n_q      <= STB_OFF;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            ext_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            last_q      <= last_d;
            gnt_ext_q   <= gnt_ext_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_n_q      <= rd_n_d;
            wr_n_q      <= wr_n_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ext_ack_q   <= ext_ack_d;
        end
    end

    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign ram_rd_n  = rd_n_q;
    assign ram_wr_n  = wr_n_q;
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ext_ack   = ext_ack_q;
    assign busy      = (state_q != IDLE);
    assign gnt_ext   = gnt_ext_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: WAIT_CYCLES=1 instance with a RAM array, plus a WAIT_CYCLES=0 instance.
// Expected winners follow RAM_ARB_FIXED_PRIO_EN when it is defined for the build.
module tb_ram_port_arbiter;

  localparam int WAIT = 1;

  int checks = 0;
  int errors = 0;

  logic       clk = 1'b0;
  logic       Reset_in;

  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [7:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic [7:0] cpu_rdata, ext_rdata, ram_addr, ram_wdata, ram_rdata;
  logic       cpu_ack, ext_ack, ram_rd_n, ram_wr_n, busy, gnt_ext;

  logic       z_cpu_req, z_cpu_we, z_ext_req, z_ext_we;
  logic [7:0] z_cpu_addr, z_cpu_wdata, z_ext_addr, z_ext_wdata;
  logic [7:0] z_cpu_rdata, z_ext_rdata, z_ram_addr, z_ram_wdata, z_ram_rdata;
  logic       z_cpu_ack, z_ext_ack, z_ram_rd_n, z_ram_wr_n, z_busy, z_gnt_ext;

  logic [7:0] ram [256];
  logic       pre_en;
  logic [7:0] pre_addr, pre_val;

  logic [7:0] model_mem [256];
  bit         model_last;
  logic [7:0] exp_cpu_rd, exp_ext_rd;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pre_en) ram[pre_addr] <= pre_val;
    else if (!ram_wr_n) ram[ram_addr] <= ram_wdata;
  end
  assign ram_rdata   = ram[ram_addr];
  assign z_ram_rdata = z_ram_addr ^ 8'hA5;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WAIT)) u_dut (
    .clk(clk), .Reset_in(Reset_in),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_rd_n(ram_rd_n), .ram_wr_n(ram_wr_n), .busy(busy), .gnt_ext(gnt_ext)
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .Reset_in(Reset_in),
    .cpu_req(z_cpu_req), .cpu_we(z_cpu_we), .cpu_addr(z_cpu_addr), .cpu_wdata(z_cpu_wdata),
    .cpu_rdata(z_cpu_rdata), .cpu_ack(z_cpu_ack),
    .ext_req(z_ext_req), .ext_we(z_ext_we), .ext_addr(z_ext_addr), .ext_wdata(z_ext_wdata),
    .ext_rdata(z_ext_rdata), .ext_ack(z_ext_ack),
    .ram_addr(z_ram_addr), .ram_wdata(z_ram_wdata), .ram_rdata(z_ram_rdata),
    .ram_rd_n(z_ram_rd_n), .ram_wr_n(z_ram_wr_n), .busy(z_busy), .gnt_ext(z_gnt_ext)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner by the arbitration rule: 0 = CPU, 1 = loader
  function automatic bit model_pick(input bit c, input bit e);
`ifdef RAM_ARB_FIXED_PRIO_EN
    return !c && e;
`else
    if (c && e) return !model_last;
    return !c && e;
`endif
  endfunction

  task automatic preset(input logic [7:0] a, input logic [7:0] v);
    pre_addr = a;
    pre_val  = v;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
    model_mem[a] = v;
  endtask

  // Inputs are already driven and the DUT is in IDLE; drop: 0 none, 1 winner, 2 both
  task automatic check_access(input bit win_ext, input int drop);
    logic       we;
    logic [7:0] a, d;
    we = win_ext ? ext_we : cpu_we;
    a  = win_ext ? ext_addr : cpu_addr;
    d  = win_ext ? ext_wdata : cpu_wdata;
    for (int c = 0; c <= WAIT; c++) begin
      @(negedge clk);
      chk("acc_rd_n", ram_rd_n, we);
      chk("acc_wr_n", ram_wr_n, !we);
      chk("acc_addr", ram_addr, a);
      if (we) chk("acc_wdata", ram_wdata, d);
      chk("acc_busy", busy, 1'b1);
      chk("acc_gnt_ext", gnt_ext, win_ext);
      chk("acc_acks", {cpu_ack, ext_ack}, 2'b00);
    end
    @(negedge clk);
    chk("done_strobes", {ram_rd_n, ram_wr_n}, 2'b11);
    chk("done_acks", {cpu_ack, ext_ack}, {!win_ext, win_ext});
    if (we) begin
      model_mem[a] = d;
      chk("done_ram_written", ram[a], d);
    end else if (win_ext) begin
      exp_ext_rd = model_mem[a];
    end else begin
      exp_cpu_rd = model_mem[a];
    end
    chk("done_cpu_rdata", cpu_rdata, exp_cpu_rd);
    chk("done_ext_rdata", ext_rdata, exp_ext_rd);
    model_last = win_ext;
    if (drop == 2 || (drop == 1 && !win_ext)) cpu_req = 1'b0;
    if (drop == 2 || (drop == 1 && win_ext))  ext_req = 1'b0;
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_strobes", {ram_rd_n, ram_wr_n}, 2'b11);
    chk("idle_acks", {cpu_ack, ext_ack}, 2'b00);
    chk("idle_gnt_ext", gnt_ext, win_ext);
  endtask

  task automatic model_reset();
    model_last = 1'b1;
    exp_cpu_rd = 8'h00;
    exp_ext_rd = 8'h00;
  endtask

  task automatic pulse_reset();
    Reset_in = 1'b1;
    @(negedge clk);
    Reset_in = 1'b0;
    model_reset();
  endtask

  initial begin
    bit w;
    Reset_in = 1'b1;
    {cpu_req, cpu_we, ext_req, ext_we} = '0;
    {cpu_addr, cpu_wdata, ext_addr, ext_wdata} = '0;
    {z_cpu_req, z_cpu_we, z_ext_req, z_ext_we} = '0;
    {z_cpu_addr, z_cpu_wdata, z_ext_addr, z_ext_wdata} = '0;
    pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_strobes", {ram_rd_n, ram_wr_n}, 2'b11);
    chk("rst_addr_wdata", {ram_addr, ram_wdata}, 16'h0000);
    chk("rst_rdata", {cpu_rdata, ext_rdata}, 16'h0000);
    chk("rst_ctrl", {cpu_ack, ext_ack, busy, gnt_ext}, 4'b0000);

    for (int i = 0; i < 256; i++) preset(8'(i), 8'($urandom));
    preset(8'h10, 8'h5A);
    preset(8'h30, 8'h11);
    preset(8'h31, 8'h22);
    Reset_in = 1'b0;
    @(negedge clk);

    // CPU read of 0x10
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    check_access(model_pick(1, 0), 2);
    chk("cpu_read_5a", cpu_rdata, 8'h5A);

    // Loader write 0xC3 to 0x20
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 8'h20; ext_wdata = 8'hC3;
    check_access(model_pick(0, 1), 2);
    chk("ext_write_c3", ram[8'h20], 8'hC3);

    // rdata of one port survives the other port's read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h30;
    check_access(model_pick(1, 0), 2);
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 8'h31;
    check_access(model_pick(0, 1), 2);
    chk("hold_cpu_11", cpu_rdata, 8'h11);
    chk("ext_read_22", ext_rdata, 8'h22);

    // Both held continuously for four accesses
    pulse_reset();
    cpu_we = 1'b0; cpu_addr = 8'($urandom);
    ext_we = 1'b0; ext_addr = 8'($urandom);
    cpu_req = 1'b1; ext_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = model_pick(1, 1);
      check_access(w, (i == 3) ? 2 : 0);
    end

    // Reset in the second ACCESS cycle abandons the access
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    @(negedge clk);
    chk("rstmid_rd_low", ram_rd_n, 1'b0);
    @(posedge clk);
    #2 Reset_in = 1'b1;
    #1;
    chk("rstmid_strobes", {ram_rd_n, ram_wr_n}, 2'b11);
    chk("rstmid_busy_ack", {busy, cpu_ack, ext_ack}, 3'b000);
    cpu_req = 1'b0;
    @(negedge clk);
    Reset_in = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rstmid_no_ack", {busy, cpu_ack, ext_ack}, 3'b000);
    end
    cpu_req = 1'b1; ext_req = 1'b1; cpu_addr = 8'h30; ext_addr = 8'h31;
    w = model_pick(1, 1);
    check_access(w, 1);
    check_access(model_pick(w == 1'b1, w == 1'b0), 2);

    // Randomized single-port accesses
    for (int i = 0; i < 24; i++) begin
      bit p;
      p = 1'($urandom_range(0, 1));
      if (p) begin
        ext_we = 1'($urandom); ext_addr = 8'($urandom); ext_wdata = 8'($urandom); ext_req = 1'b1;
      end else begin
        cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom); cpu_req = 1'b1;
      end
      check_access(model_pick(!p, p), 2);
    end

    // Randomized contention pairs
    for (int i = 0; i < 8; i++) begin
      cpu_we = 1'($urandom); cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
      ext_we = 1'($urandom); ext_addr = 8'($urandom); ext_wdata = 8'($urandom);
      cpu_req = 1'b1; ext_req = 1'b1;
      w = model_pick(1, 1);
      check_access(w, 1);
      check_access(model_pick(w == 1'b1, w == 1'b0), 2);
    end

    // Zero wait-state instance
    for (int i = 0; i < 3; i++) begin
      logic [7:0] a;
      a = 8'($urandom);
      z_cpu_req = 1'b1; z_cpu_we = 1'b0; z_cpu_addr = a;
      @(negedge clk);
      chk("z_rd_low", z_ram_rd_n, 1'b0);
      chk("z_addr", z_ram_addr, a);
      chk("z_no_ack", z_cpu_ack, 1'b0);
      @(negedge clk);
      chk("z_rd_high", {z_ram_rd_n, z_ram_wr_n}, 2'b11);
      chk("z_ack", {z_cpu_ack, z_ext_ack}, 2'b10);
      chk("z_rdata", z_cpu_rdata, a ^ 8'hA5);
      z_cpu_req = 1'b0;
      @(negedge clk);
      chk("z_idle", {z_busy, z_cpu_ack, z_gnt_ext}, 3'b000);
      chk("z_untouched", {z_ext_rdata, z_ram_wdata}, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port program/data RAM between two requesters:
  - the CPU controller's memory path (IR/MDR fetch, MOVIAR-style writes);
  - an external loader/debug port used to download programs and inspect memory.
- Owns the RAM strobes (active-low, matching the controller's RAM_RD/RAM_WR sense), address and write data.
- Sequences each access through a fixed wait-state window and returns a one-cycle acknowledge to the winner.

Parameters:
- ADDR_W, 8, RAM address width.
- DATA_W, 8, RAM data width.
- WAIT_CYCLES, 1, extra cycles the strobe is held beyond the first access cycle (0 allowed).

Ports:
- clk  in  1  system clock; all state on rising edge.
- Reset_in  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  CPU access request; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1.
- cpu_ack  out  1  one-cycle completion pulse.
- ext_req, ext_we, ext_addr, ext_wdata, ext_rdata, ext_ack  as the CPU set, for the loader port.
- ram_addr  out  ADDR_W  registered RAM address.
- ram_wdata  out  DATA_W  registered RAM write data.
- ram_rdata  in  DATA_W  RAM read data.
- ram_rd_n  out  1  active-low read strobe.
- ram_wr_n  out  1  active-low write strobe.
- busy  out  1  1 whenever state is not IDLE.
- gnt_ext  out  1  1 while the current/last grant belongs to ext.

Behaviour:
- Reset values (immediate, asynchronous):
  - state=IDLE; ram_rd_n=1, ram_wr_n=1;
  - ram_addr=0, ram_wdata=0, cpu_rdata=0, ext_rdata=0;
  - cpu_ack=0, ext_ack=0, busy=0;
  - last_grant=EXT, so the CPU wins the first tie; gnt_ext=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Samples cpu_req/ext_req each edge.
  - If either is set: pick a winner, register addr/wdata/we into ram_addr/ram_wdata, set wait counter cnt=WAIT_CYCLES, go ACCESS.
  - Arbitration is round-robin. On a tie the requester not equal to last_grant wins; a single requester always wins.
  - last_grant updates at grant.
- ACCESS:
  - Read: ram_rd_n=0. Write: ram_wr_n=0. The other strobe stays 1.
  - Address and data are constant for the whole state.
  - Each edge with cnt!=0 decrements cnt.
  - At the edge with cnt==0:
    - read: ram_rdata is captured into the winner's rdata register;
    - both strobes return to 1;
    - go DONE.
  - ACCESS therefore lasts exactly WAIT_CYCLES+1 cycles.
- DONE:
  - The winner's ack=1 for exactly one cycle; the loser's ack stays 0.
  - Next state is always IDLE. There is no grant directly from DONE, which guarantees one strobe-free cycle between accesses.
- Latency: a request sampled in IDLE at edge k gives strobe low during cycles k+1..k+1+WAIT_CYCLES and ack during cycle k+WAIT_CYCLES+2. Default: 3 cycles.
- Requester rules:
  - req, we, addr and wdata must stay stable from assertion until ack.
  - req must drop at the edge that ends the ack cycle unless a new access is intended. If req is still high in IDLE, it is a new request.
- Request changes during ACCESS/DONE are ignored; the loser keeps waiting.
- Reset mid-ACCESS: strobes go high immediately, the in-flight access is abandoned with no ack, and requesters must re-request.
- rdata registers hold their last value until the next read completes for that port. A write does not modify rdata.
- cnt width = max(1, $clog2(WAIT_CYCLES+1)).

Optional Feature:
- Macro: RAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, CPU always wins a tie, and last_grant is ignored (still reported via gnt_ext). The loader can starve while the CPU streams requests.
- Undefined: round-robin as above.

Decomposition:
- Package ram_arb_pkg:
  - state enum {IDLE, ACCESS, DONE};
  - grant enum {GNT_CPU, GNT_EXT};
  - strobe idle constant STB_OFF=1'b1.
- One sub-module ram_arb_pick: combinational two-way pick taking cpu_req, ext_req and last_grant, returning the winner. It contains the RAM_RAM_ARB_FIXED_PRIO_EN variant only as RAM_ARB_FIXED_PRIO_EN (single macro, as named above).
- FSM, counter and registers live in the top.

Test Plan:
- Reset then CPU read addr 0x10, RAM holds 0x5A, WAIT_CYCLES=1 -> ram_rd_n low for 2 cycles, cpu_ack on the 3rd cycle after sampling, cpu_rdata=0x5A, ext_ack=0.
- ext write addr 0x20 data 0xC3 -> ram_wr_n low for 2 cycles with ram_addr=0x20 and ram_wdata=0xC3 stable; ext_ack one cycle; RAM[0x20]=0xC3 afterwards.
- cpu_req and ext_req both held continuously, four accesses -> grants CPU, EXT, CPU, EXT, with one strobe-free IDLE cycle between each. With RAM_ARB_FIXED_PRIO_EN -> CPU four times and ext_ack never asserted.
- Reset_in pulsed during the second ACCESS cycle -> strobes high the same cycle, no ack, busy=0. The next CPU request wins the tie.
- WAIT_CYCLES=0: CPU read -> strobe low for exactly 1 cycle, ack 2 cycles after sampling.
- CPU read returns 0x11, then ext read returns 0x22 -> cpu_rdata still 0x11 after ext_ack, ext_rdata=0x22.
